// File: rtl/sdp_ram_ctrl.sv
// sdp_ram_ctrl: single-clock simple-dual-port RAM with byte-enabled writes, selectable
// read-during-write behaviour, a hardware clear sequencer and a read-valid pipeline.
//
// Parameters:
//   DATA_W    word width (multiple of 8)
//   ADDR_W    address width
//   DEPTH     number of words, 2 <= DEPTH <= 2**ADDR_W
//   RDW_MODE  same-address collision: 0 = old data, 1 = write-through (new bytes merged)
//   INIT_VAL  value written to every word by the clear sequencer
//
// Ports:
//   i_sys_clk  clock (rising edge)
//   i_rst_n    asynchronous active-low reset; restarts the clear sequence
//   i_clr      one-cycle re-clear request, honoured only while o_busy = 0
//   o_busy     clear sequence in progress
//   i_ena, i_wea, i_addra, i_dina   write port (byte enables per 8-bit lane)
//   i_enb, i_addrb                  read request
//   o_doutb    read data, held between reads
//   o_validb   one-cycle pulse qualifying o_doutb
//   o_oob      one-cycle pulse flagging an out-of-range read and/or dropped write
//
// Build option: define SDP_RAM_OUT_REG_EN to add an output register stage (read latency 2).

module sdp_ram_ctrl #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DEPTH    = 256,
    parameter int unsigned       RDW_MODE = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                i_sys_clk,
    input  logic                i_rst_n,
    input  logic                i_clr,
    output logic                o_busy,
    input  logic                i_ena,
    input  logic [DATA_W/8-1:0] i_wea,
    input  logic [ADDR_W-1:0]   i_addra,
    input  logic [DATA_W-1:0]   i_dina,
    input  logic                i_enb,
    input  logic [ADDR_W-1:0]   i_addrb,
    output logic [DATA_W-1:0]   o_doutb,
    output logic                o_validb,
    output logic                o_oob
);

    localparam int unsigned       NumBytes = DATA_W / 8;
    localparam int unsigned       IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DepthLim = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LastPtr  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        StClear,
        StReady
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    logic [DATA_W-1:0] mem [DEPTH];

    // Shared memory write port, used by either the clear sequencer or the user.
    logic                mem_we;
    logic [IdxW-1:0]     mem_idx;
    logic [DATA_W-1:0]   mem_wdata;
    logic [NumBytes-1:0] mem_be;

    logic wra_in_range;
    logic rdb_in_range;
    logic user_wr_req;
    logic rd_fire;
    logic wr_oob;
    logic collide;

    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_data;

    // First output stage (read latency 1).
    logic              valid1_q, valid1_d;
    logic              oob1_q, oob1_d;
    logic [DATA_W-1:0] dout1_q, dout1_d;

    assign wra_in_range = ({1'b0, i_addra} < DepthLim);
    assign rdb_in_range = ({1'b0, i_addrb} < DepthLim);
    assign user_wr_req  = i_ena && (|i_wea);

    // Control FSM and write-port arbitration.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mem_we    = 1'b0;
        mem_idx   = '0;
        mem_wdata = '0;
        mem_be    = '0;
        rd_fire   = 1'b0;
        wr_oob    = 1'b0;

        case (state_q)
            StClear: begin
                mem_we    = 1'b1;
                mem_idx   = ptr_q[IdxW-1:0];
                mem_wdata = INIT_VAL;
                mem_be    = '1;
                if (ptr_q == LastPtr) begin
                    state_d = StReady;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            StReady: begin
                rd_fire = i_enb;
                if (user_wr_req) begin
                    if (wra_in_range) begin
                        mem_we    = 1'b1;
                        mem_idx   = i_addra[IdxW-1:0];
                        mem_wdata = i_dina;
                        mem_be    = i_wea;
                    end else begin
                        wr_oob = 1'b1;
                    end
                end
                // Accesses presented alongside i_clr are still serviced above.
                if (i_clr) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                ptr_d   = '0;
            end
        endcase
    end

    // Read path: the array is read before this edge's write lands, so the raw word is
    // always the pre-write value; write-through mode patches in the written bytes.
    assign collide = rd_fire && mem_we && (i_addrb == i_addra);

    always_comb begin
        rd_word = mem[i_addrb[IdxW-1:0]];
        rd_data = rd_word;
        if ((RDW_MODE == 1) && collide) begin
            for (int k = 0; k < NumBytes; k++) begin
                if (i_wea[k]) begin
                    rd_data[8*k +: 8] = i_dina[8*k +: 8];
                end
            end
        end
        if (!rdb_in_range) begin
            rd_data = '0;
        end
    end

    always_comb begin
        valid1_d = rd_fire;
        // A simultaneous out-of-range read and dropped write share one pulse.
        oob1_d   = (rd_fire && !rdb_in_range) || wr_oob;
        dout1_d  = rd_fire ? rd_data : dout1_q;
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StClear;
            ptr_q    <= '0;
            valid1_q <= 1'b0;
            oob1_q   <= 1'b0;
            dout1_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            valid1_q <= valid1_d;
            oob1_q   <= oob1_d;
            dout1_q  <= dout1_d;
        end
    end

    // Storage is deliberately not reset; only the clear sequencer initialises it.
    always_ff @(posedge i_sys_clk) begin
        if (mem_we) begin
            for (int k = 0; k < NumBytes; k++) begin
                if (mem_be[k]) begin
                    mem[mem_idx][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

    assign o_busy = (state_q == StClear);

`ifdef SDP_RAM_OUT_REG_EN
    logic              valid2_q, valid2_d;
    logic              oob2_q, oob2_d;
    logic [DATA_W-1:0] dout2_q, dout2_d;

    always_comb begin
        valid2_d = valid1_q;
        oob2_d   = oob1_q;
        dout2_d  = dout1_q;
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid2_q <= 1'b0;
            oob2_q   <= 1'b0;
            dout2_q  <= '0;
        end else begin
            valid2_q <= valid2_d;
            oob2_q   <= oob2_d;
            dout2_q  <= dout2_d;
        end
    end

    assign o_validb = valid2_q;
    assign o_oob    = oob2_q;
    assign o_doutb  = dout2_q;
`else
    assign o_validb = valid1_q;
    assign o_oob    = oob1_q;
    assign o_doutb  = dout1_q;
`endif

endmodule

// File: tb/tb_sdp_ram_ctrl.sv
// Self-checking bench for sdp_ram_ctrl. Two instances share one stimulus stream:
// dut0 uses the default geometry (256 words, old-data collisions, INIT_VAL 0) and
// dut1 uses 200 words, write-through collisions and INIT_VAL 16'h5A5A.

module tb_sdp_ram_ctrl;

`ifdef SDP_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        ena;
    logic [1:0]  wea;
    logic [7:0]  addra;
    logic [15:0] dina;
    logic        enb;
    logic [7:0]  addrb;

    logic [1:0]  busy_w;
    logic [1:0]  valid_w;
    logic [1:0]  oob_w;
    logic [15:0] dout_w [2];

    int n_tests;
    int n_fail;

    sdp_ram_ctrl u_dut0 (
        .i_sys_clk (clk),
        .i_rst_n   (rst_n),
        .i_clr     (clr),
        .o_busy    (busy_w[0]),
        .i_ena     (ena),
        .i_wea     (wea),
        .i_addra   (addra),
        .i_dina    (dina),
        .i_enb     (enb),
        .i_addrb   (addrb),
        .o_doutb   (dout_w[0]),
        .o_validb  (valid_w[0]),
        .o_oob     (oob_w[0])
    );

    sdp_ram_ctrl #(
        .DATA_W   (16),
        .ADDR_W   (8),
        .DEPTH    (200),
        .RDW_MODE (1),
        .INIT_VAL (16'h5A5A)
    ) u_dut1 (
        .i_sys_clk (clk),
        .i_rst_n   (rst_n),
        .i_clr     (clr),
        .o_busy    (busy_w[1]),
        .i_ena     (ena),
        .i_wea     (wea),
        .i_addra   (addra),
        .i_dina    (dina),
        .i_enb     (enb),
        .i_addrb   (addrb),
        .o_doutb   (dout_w[1]),
        .o_validb  (valid_w[1]),
        .o_oob     (oob_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: word arrays, remaining-clear-cycle counters and a short
    // history of per-cycle results from which the latency-delayed outputs are taken.
    logic [15:0] m_mem [2][256];
    int          m_depth [2];
    int          m_rdw [2];
    logic [15:0] m_init [2];
    int          m_clr_left [2];
    logic        p_v [2][2];
    logic        p_o [2][2];
    logic [15:0] p_d [2][2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_clr_left[k] = m_depth[k];
            for (int s = 0; s < 2; s++) begin
                p_v[k][s] = 1'b0;
                p_o[k][s] = 1'b0;
                p_d[k][s] = 16'h0000;
            end
        end
    endtask

    // Effect of one rising edge given the currently driven inputs.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic        nv;
            logic        no;
            logic [15:0] nd;
            nv = 1'b0;
            no = 1'b0;
            nd = p_d[k][0];
            if (m_clr_left[k] > 0) begin
                m_mem[k][m_depth[k] - m_clr_left[k]] = m_init[k];
                m_clr_left[k]--;
            end else begin
                if (enb) begin
                    nv = 1'b1;
                    if (int'(addrb) < m_depth[k]) begin
                        nd = m_mem[k][addrb];
                        if (m_rdw[k] == 1 && ena && wea != 2'b00 && addra == addrb) begin
                            for (int b = 0; b < 2; b++) begin
                                if (wea[b]) nd[8*b +: 8] = dina[8*b +: 8];
                            end
                        end
                    end else begin
                        nd = 16'h0000;
                        no = 1'b1;
                    end
                end
                if (ena && wea != 2'b00) begin
                    if (int'(addra) < m_depth[k]) begin
                        for (int b = 0; b < 2; b++) begin
                            if (wea[b]) m_mem[k][addra][8*b +: 8] = dina[8*b +: 8];
                        end
                    end else begin
                        no = 1'b1;
                    end
                end
                if (clr) m_clr_left[k] = m_depth[k];
            end
            p_v[k][1] = p_v[k][0];
            p_o[k][1] = p_o[k][0];
            p_d[k][1] = p_d[k][0];
            p_v[k][0] = nv;
            p_o[k][0] = no;
            p_d[k][0] = nd;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("busy%0d", k), 32'(busy_w[k]), 32'(m_clr_left[k] > 0));
            check_val($sformatf("valid%0d", k), 32'(valid_w[k]), 32'(p_v[k][LAT-1]));
            check_val($sformatf("oob%0d", k), 32'(oob_w[k]), 32'(p_o[k][LAT-1]));
            check_val($sformatf("dout%0d", k), 32'(dout_w[k]), 32'(p_d[k][LAT-1]));
        end
    endtask

    // Called at a falling edge: drive, advance the model over the next rising
    // edge, then check at the following falling edge.
    task automatic do_cycle(input logic i_ena_v, input logic [1:0] i_wea_v,
                            input logic [7:0] i_aa, input logic [15:0] i_da,
                            input logic i_enb_v, input logic [7:0] i_ab, input logic i_clr_v);
        ena   = i_ena_v;
        wea   = i_wea_v;
        addra = i_aa;
        dina  = i_da;
        enb   = i_enb_v;
        addrb = i_ab;
        clr   = i_clr_v;
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 2'b00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic hold_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_outputs();
        end
        rst_n = 1'b1;
    endtask

    // Counts busy cycles of each instance from the current (release) cycle onwards.
    task automatic measure_clear(input string tag);
        int n0;
        int n1;
        n0 = busy_w[0] ? 1 : 0;
        n1 = busy_w[1] ? 1 : 0;
        for (int i = 0; i < 270; i++) begin
            idle(1);
            if (busy_w[0]) n0++;
            if (busy_w[1]) n1++;
        end
        check_val({tag, "_len0"}, 32'(n0), 32'd256);
        check_val({tag, "_len1"}, 32'(n1), 32'd200);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_depth[0] = 256; m_rdw[0] = 0; m_init[0] = 16'h0000;
        m_depth[1] = 200; m_rdw[1] = 1; m_init[1] = 16'h5A5A;
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 256; a++) m_mem[k][a] = 16'h0000;
        end
        ena = 1'b0; wea = 2'b00; addra = '0; dina = '0;
        enb = 1'b0; addrb = '0; clr = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        hold_reset(3);
        measure_clear("init_clear");

        // Post-reset reads, back to back.
        do_cycle(1'b0, 2'b00, 8'd0, 16'h0, 1'b1, 8'd0, 1'b0);
        do_cycle(1'b0, 2'b00, 8'd0, 16'h0, 1'b1, 8'd128, 1'b0);
        do_cycle(1'b0, 2'b00, 8'd0, 16'h0, 1'b1, 8'd255, 1'b0);
        idle(2);

        // Byte enables.
        do_cycle(1'b1, 2'b11, 8'd5, 16'hABCD, 1'b0, 8'd0, 1'b0);
        do_cycle(1'b1, 2'b01, 8'd5, 16'h1234, 1'b0, 8'd0, 1'b0);
        do_cycle(1'b0, 2'b00, 8'd0, 16'h0, 1'b1, 8'd5, 1'b0);
        idle(LAT - 1);
        check_val("byte_en0", 32'(dout_w[0]), 32'h0000AB34);
        check_val("byte_en1", 32'(dout_w[1]), 32'h0000AB34);

        // Same-address collision.
        do_cycle(1'b1, 2'b11, 8'd9, 16'h1111, 1'b0, 8'd0, 1'b0);
        do_cycle(1'b1, 2'b11, 8'd9, 16'h2222, 1'b1, 8'd9, 1'b0);
        idle(LAT - 1);
        check_val("rdw_old0", 32'(dout_w[0]), 32'h00001111);
        check_val("rdw_new1", 32'(dout_w[1]), 32'h00002222);
        do_cycle(1'b0, 2'b00, 8'd0, 16'h0, 1'b1, 8'd9, 1'b0);
        idle(LAT - 1);
        check_val("rdw_after0", 32'(dout_w[0]), 32'h00002222);
        check_val("rdw_after1", 32'(dout_w[1]), 32'h00002222);

        // Out of range for dut1 only (210 >= 200).
        do_cycle(1'b1, 2'b11, 8'd210, 16'h7777, 1'b0, 8'd0, 1'b0);
        idle(LAT - 1);
        check_val("wr_oob1", 32'(oob_w[1]), 32'd1);
        check_val("wr_oob0", 32'(oob_w[0]), 32'd0);
        do_cycle(1'b0, 2'b00, 8'd0, 16'h0, 1'b1, 8'd210, 1'b0);
        idle(LAT - 1);
        check_val("rd_oob1", 32'({valid_w[1], oob_w[1], dout_w[1]}), 32'h00030000);
        check_val("rd_in0", 32'({valid_w[0], oob_w[0], dout_w[0]}), 32'h00027777);
        // Simultaneous out-of-range read and write.
        do_cycle(1'b1, 2'b01, 8'd220, 16'h0101, 1'b1, 8'd230, 1'b0);
        idle(2);

        // Randomized traffic, with occasional re-clear requests.
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] aa;
            logic [7:0] ab;
            aa = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            ab = ($urandom_range(0, 2) == 0) ? aa :
                 (($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom));
            do_cycle(1'($urandom), 2'($urandom), aa, 16'($urandom), 1'($urandom), ab,
                     1'($urandom_range(0, 299) == 0));
        end
        idle(260);

        // Re-clear after writing data, then sweep every word.
        for (int a = 0; a < 8; a++) begin
            do_cycle(1'b1, 2'b11, 8'(a * 31), 16'($urandom), 1'b0, 8'd0, 1'b0);
        end
        do_cycle(1'b0, 2'b00, 8'd0, 16'h0, 1'b0, 8'd0, 1'b1);
        idle(260);
        for (int a = 0; a < 256; a++) begin
            do_cycle(1'b0, 2'b00, 8'd0, 16'h0, 1'b1, 8'(a), 1'b0);
        end
        idle(2);

        // Reset with reads in flight.
        do_cycle(1'b1, 2'b11, 8'd3, 16'hBEEF, 1'b0, 8'd0, 1'b0);
        do_cycle(1'b0, 2'b00, 8'd0, 16'h0, 1'b1, 8'd3, 1'b0);
        do_cycle(1'b0, 2'b00, 8'd0, 16'h0, 1'b1, 8'd3, 1'b0);
        hold_reset(1);
        check_val("rst_valid0", 32'(valid_w[0]), 32'd0);
        measure_clear("rd_rst_clear");

        // Reset while the clear pointer is at 100.
        do_cycle(1'b0, 2'b00, 8'd0, 16'h0, 1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 300 && m_clr_left[0] > 156; i++) idle(1);
        check_val("ptr_at_100", 32'(m_clr_left[0]), 32'd156);
        hold_reset(2);
        measure_clear("mid_clear");
        do_cycle(1'b0, 2'b00, 8'd0, 16'h0, 1'b1, 8'd100, 1'b0);
        do_cycle(1'b0, 2'b00, 8'd0, 16'h0, 1'b1, 8'd199, 1'b0);
        idle(LAT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
